seq_magnitude_comparator: RTL and testbench
===========================================

// Module: seq_magnitude_comparator
// PURPOSE
//  Multi-cycle WIDTH-bit unsigned magnitude comparator built around a 2-bit slice compare.
//  - Scans operands MSB-first, one 2-bit slice per clock.
//  - Sits above the 2-bit comparator stage: feeds it slices, consumes its gt/eq/lt.
//  - Handshake: start/busy/done, so wide operands compare without a deep combinational chain.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 2 (NSL = WIDTH/2 slices)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  a            in   WIDTH  operand A, unsigned; sampled when start is accepted
//  b            in   WIDTH  operand B, unsigned; sampled when start is accepted
//  busy         out  1      comparison in progress
//  done         out  1      one-cycle pulse; result valid from this cycle on
//  a_gt_b       out  1      registered result A>B
//  a_eq_b       out  1      registered result A==B
//  a_lt_b       out  1      registered result A<B
//  slices_used  out  $clog2(NSL+1)  slices examined by last comparison (1..NSL)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, a_gt_b=a_eq_b=a_lt_b=0, slices_used=0.
//    A comparison in flight is aborted and its result discarded.
//  - FSM states: IDLE, SCAN.
//    IDLE: start=1 -> latch a,b; idx=NSL-1; cnt=0; hit=0; go SCAN.
//    SCAN: compare slice {a[2*idx+1],a[2*idx]} vs {b[2*idx+1],b[2*idx]} (bit 2*idx+1 = MSB).
//          cnt increments once per slice examined.
//          Decision -> register result, slices_used=cnt+1, done=1 for one cycle, go IDLE.
//          Otherwise idx decrements; stay in SCAN.
//  - Slice result: gt if a_s>b_s, lt if a_s<b_s, else eq.
//    The first non-eq slice from the MSB end fixes the final result. All slices eq -> a_eq_b=1.
//  - Exactly one of gt/eq/lt is high after any completed comparison; all three are 0 only after reset.
//  - busy: 1 from the cycle after start is accepted up to and including the cycle done is high.
//    busy is 0 in IDLE otherwise.
//  - Latency: start accepted at edge E0 -> done high in the cycle after edge E(slices_used).
//    This gives 1..NSL cycles.
//  - Results and slices_used hold until the next decision; they do not change during SCAN.
//  - start while busy=1 and state=SCAN: ignored. a/b changes during SCAN: no effect (latched).
//  - The done cycle is an IDLE cycle: start=1 there is accepted (back-to-back).
//    Old results stay visible until the new decision.
//  - WIDTH=2: NSL=1; every comparison takes 1 cycle.
// CONFIGURATION
//  SEQCMP_EARLY_EXIT_EN defined:
//    SCAN ends at the first non-eq slice, or after slice 0.
//    slices_used = index of the deciding slice from the MSB (1-based); NSL when equal.
//  SEQCMP_EARLY_EXIT_EN undefined:
//    All NSL slices are always scanned, giving constant latency NSL.
//    The first non-eq slice is held in a sticky flag; later slices cannot override it.
//    slices_used = NSL always.
// TESTING  (WIDTH=8, NSL=4)
//  1. a=8'hB4, b=8'h74, start 1 cycle -> a_gt_b=1, others 0.
//     Early-exit: done 1 cycle after start, slices_used=1. Otherwise: 4 cycles, slices_used=4.
//  2. a=8'h5A, b=8'h5A -> a_eq_b=1; done 4 cycles after start; slices_used=4 in both builds.
//  3. a=8'h12, b=8'h13 -> a_lt_b=1 (decided at slice 0); done after 4 cycles; slices_used=4.
//  4. Start a=8'h00, b=8'hFF; assert start with a=8'hFF, b=8'h00 while busy.
//     -> second start ignored; a_lt_b=1; exactly one done pulse.
//  5. Start a=8'h40, b=8'h41; assert rst 1 cycle later.
//     -> next cycle busy=0, done=0, all results 0, slices_used=0; no done pulse follows.
//  6. Back-to-back: start a=8'hC0,b=8'h80, then start again on the done cycle with a=8'h01,b=8'h02.
//     -> first done with a_gt_b=1; second accepted with no idle gap; second done with a_lt_b=1.
//     -> results remain a_gt_b=1 until the second decision.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// ============================================================================
// Module  : seq_magnitude_comparator
// Brief   : Multi-cycle unsigned magnitude comparator, one 2-bit slice per clock,
//           scanned MSB-first. Optional macro SEQCMP_EARLY_EXIT_EN stops the scan
//           at the first differing slice.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            busy,
  output logic                            done,
  output logic                            a_gt_b,
  output logic                            a_eq_b,
  output logic                            a_lt_b,
  output logic [$clog2(WIDTH/2+1)-1:0]    slices_used
);

  localparam int NSL   = WIDTH / 2;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int CNT_W = $clog2(NSL + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic [CNT_W-1:0]   used_q, used_d;
`ifndef SEQCMP_EARLY_EXIT_EN
  logic               hit_q, hit_d;
  logic               hit_gt_q, hit_gt_d;
`endif

  logic [1:0] a_s, b_s;
  logic       s_gt, s_lt;
  logic       fin_gt, fin_lt;
  logic       decide;

  // Current 2-bit slice; bit 2*idx+1 is the slice MSB.
  assign a_s  = a_q[{idx_q, 1'b0} +: 2];
  assign b_s  = b_q[{idx_q, 1'b0} +: 2];
  assign s_gt = (a_s > b_s);
  assign s_lt = (a_s < b_s);

`ifdef SEQCMP_EARLY_EXIT_EN
  assign fin_gt = s_gt;
  assign fin_lt = s_lt;
  assign decide = s_gt | s_lt | (idx_q == '0);
`else
  // A slice that already differed wins over everything below it.
  assign fin_gt = hit_q ? hit_gt_q  : s_gt;
  assign fin_lt = hit_q ? !hit_gt_q : s_lt;
  assign decide = (idx_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    used_d  = used_q;
`ifndef SEQCMP_EARLY_EXIT_EN
    hit_d    = hit_q;
    hit_gt_d = hit_gt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NSL - 1);
          cnt_d   = '0;
`ifndef SEQCMP_EARLY_EXIT_EN
          hit_d    = 1'b0;
          hit_gt_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (decide) begin
          gt_d    = fin_gt;
          lt_d    = fin_lt;
          eq_d    = !(fin_gt | fin_lt);
          used_d  = cnt_q + CNT_W'(1);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
`ifndef SEQCMP_EARLY_EXIT_EN
          if (!hit_q && (s_gt || s_lt)) begin
            hit_d    = 1'b1;
            hit_gt_d = s_gt;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      used_q  <= '0;
`ifndef SEQCMP_EARLY_EXIT_EN
      hit_q    <= 1'b0;
      hit_gt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      used_q  <= used_d;
`ifndef SEQCMP_EARLY_EXIT_EN
      hit_q    <= hit_d;
      hit_gt_q <= hit_gt_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign a_gt_b      = gt_q;
  assign a_eq_b      = eq_q;
  assign a_lt_b      = lt_q;
  assign slices_used = used_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
// ============================================================================
// Module  : tb_seq_magnitude_comparator
// Brief   : Directed plus randomized bench against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_magnitude_comparator;

  localparam int W     = 8;
  localparam int NSL   = W / 2;
  localparam int CNT_W = $clog2(NSL + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     a_in = '0;
  logic [W-1:0]     b_in = '0;
  logic             busy, done, a_gt_b, a_eq_b, a_lt_b;
  logic [CNT_W-1:0] slices_used;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [2:0]       prev_res = 3'b000;

  seq_magnitude_comparator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a_in),
    .b           (b_in),
    .busy        (busy),
    .done        (done),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b),
    .a_lt_b      (a_lt_b),
    .slices_used (slices_used)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: result from plain unsigned compare; slice count from the
  // position of the first differing 2-bit group counted from the MSB.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [2:0] res, output int used);
    res  = (av > bv) ? 3'b100 : ((av == bv) ? 3'b010 : 3'b001);
    used = NSL;
`ifdef SEQCMP_EARLY_EXIT_EN
    for (int k = 1; k <= NSL; k++) begin
      if (((av >> (W - 2*k)) & 3) != ((bv >> (W - 2*k)) & 3)) begin
        used = k;
        break;
      end
    end
`endif
  endtask

  // Called at #1 after a clock edge with the DUT able to accept start.
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noisy);
    logic [2:0] eres;
    int         eused;
    int         lat;
    bit         got;
    model(av, bv, eres, eused);
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(posedge clk); #1;
    if (noisy) begin
      a_in = bv;
      b_in = av;
    end else begin
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
    end
    lat = 0;
    got = 0;
    while (!got && lat < NSL + 2) begin
      check("busy_scan", busy, 1);
      check("hold_res", {a_gt_b, a_eq_b, a_lt_b}, prev_res);
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      got   = done;
    end
    check("done_seen", got, 1);
    check("latency", lat, eused);
    check("busy_done", busy, 1);
    check("result", {a_gt_b, a_eq_b, a_lt_b}, eres);
    check("slices_used", slices_used, eused);
    prev_res = eres;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_hold", {a_gt_b, a_eq_b, a_lt_b}, prev_res);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    check("rst_used", slices_used, 0);
    idle_check(1);

    run_cmp(8'hB4, 8'h74, 1'b0);
    idle_check(1);
    run_cmp(8'h5A, 8'h5A, 1'b0);
    idle_check(1);
    run_cmp(8'h12, 8'h13, 1'b0);
    idle_check(1);

    // Start while busy is ignored; only one done pulse follows.
    run_cmp(8'h00, 8'hFF, 1'b1);
    idle_check(NSL + 2);

    // Reset aborts an in-flight comparison.
    start = 1'b1;
    a_in  = 8'h40;
    b_in  = 8'h41;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    check("abort_used", slices_used, 0);
    prev_res = 3'b000;
    idle_check(NSL + 2);

    // Back-to-back: second start issued in the done cycle.
    run_cmp(8'hC0, 8'h80, 1'b0);
    run_cmp(8'h01, 8'h02, 1'b0);
    idle_check(1);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      run_cmp(ra, rb, 1'b0);
      idle_check($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
